// File: rtl/lif_array.sv
// Array of N independent leaky integrate-and-fire neurons with adaptive thresholds,
// a refractory period, and a shared saturating spike counter. Results are registered one cycle after each step.
module lif_array #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int THETA0     = 230,
  parameter int THETA_INC  = 16,
  parameter int REFRAC     = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [N*W-1:0] current,
  output logic           out_valid,
  output logic [N-1:0]   spike,
  output logic [N*W-1:0] state,
  output logic [N*W-1:0] theta,
  output logic [15:0]    spike_count
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int PW = $clog2(N + 1);
  localparam logic [W-1:0]  WMAX  = '1;
  localparam logic [W-1:0]  TH0   = W'(THETA0);
  localparam logic [W:0]    INC   = (W+1)'(THETA_INC);
  localparam logic [RW-1:0] RLOAD = RW'(REFRAC);

  logic [RW-1:0]  refr     [N];
  logic [RW-1:0]  refr_nxt [N];
  logic [N*W-1:0] state_nxt;
  logic [N*W-1:0] theta_nxt;
  logic [N-1:0]   spike_nxt;
  logic [PW-1:0]  pop;
  logic [16:0]    cnt_sum;

  for (genvar i = 0; i < N; i++) begin : g_neuron
    logic [W-1:0]  s, th, cur, u, th_decay;
    logic [W:0]    u_raw, th_inc;
    logic [W-1:0]  s_nxt, th_nxt;
    logic [RW-1:0] r_nxt;
    logic          spk_nxt;

    assign s   = state[i*W +: W];
    assign th  = theta[i*W +: W];
    assign cur = current[i*W +: W];

    // Leak never underflows since s>>LEAK_SHIFT <= s; only the add can overflow.
    assign u_raw    = {1'b0, s - (s >> LEAK_SHIFT)} + {1'b0, cur};
    assign u        = u_raw[W] ? WMAX : u_raw[W-1:0];
    assign th_decay = (th > TH0) ? th - W'(1) : th;
    assign th_inc   = {1'b0, th} + INC;

    always_comb begin
      s_nxt   = s;
      th_nxt  = th;
      r_nxt   = refr[i];
      spk_nxt = 1'b0;
      if (in_valid) begin
        if (refr[i] != '0) begin
          r_nxt  = refr[i] - RW'(1);
          s_nxt  = '0;
          th_nxt = th_decay;
        end else if (u >= th) begin
          spk_nxt = 1'b1;
          s_nxt   = '0;
          r_nxt   = RLOAD;
          th_nxt  = th_inc[W] ? WMAX : th_inc[W-1:0];
        end else begin
          s_nxt  = u;
          th_nxt = th_decay;
        end
      end
    end

    assign state_nxt[i*W +: W] = s_nxt;
    assign theta_nxt[i*W +: W] = th_nxt;
    assign spike_nxt[i]        = spk_nxt;
    assign refr_nxt[i]         = r_nxt;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + PW'(spike_nxt[i]);
  end

  assign cnt_sum = {1'b0, spike_count} + 17'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= '0;
      theta       <= {N{TH0}};
      spike       <= '0;
      out_valid   <= 1'b0;
      spike_count <= '0;
      for (int i = 0; i < N; i++) refr[i] <= '0;
    end else begin
      state       <= state_nxt;
      theta       <= theta_nxt;
      spike       <= spike_nxt;
      out_valid   <= in_valid;
      spike_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      for (int i = 0; i < N; i++) refr[i] <= refr_nxt[i];
    end
  end

endmodule
